spi_eeprom_arbiter: RTL and testbench
=====================================

Name: spi_eeprom_arbiter

Overview:
- Shares the single SPI EEPROM master between N_REQ independent requesters, for example two Wishbone slave ports.
- Grants requesters round-robin and builds the 32-bit command word that the SPI master consumes:
  - [31] ready
  - [30] busy
  - [29] R/Wn
  - [14:7] data
  - [6:0] address
- Waits for the master's ready response, returns read data and an ack to the granted requester, then releases the master.
- Includes a watchdog so that a hung master cannot lock up the bus.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- TIMEOUT, 4096, maximum cycles to wait in WAIT or RELEASE before the transaction is aborted with an error.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- req_i  input  N_REQ  per-requester request level; held until ack.
- we_i  input  N_REQ  per-requester write enable (1=write, 0=read).
- addr_i  input  7*N_REQ  packed byte addresses; requester k uses [7k+6:7k].
- wdata_i  input  8*N_REQ  packed write data; requester k uses [8k+7:8k].
- ack_o  output  N_REQ  one-cycle completion pulse to the granted requester.
- err_o  output  N_REQ  one-cycle timeout pulse, asserted together with ack_o.
- rdata_o  output  8  read data; valid in the ack cycle.
- busy_o  output  1  high from grant until return to IDLE.
- spi_cmd_o  output  32  command word to the SPI master's data_in.
- spi_resp_i  input  32  SPI master's data_out.

Behaviour:
- Reset (async, rst=1):
  - State returns to IDLE.
  - spi_cmd_o=0, ack_o=0, err_o=0, rdata_o=0, busy_o=0.
  - Round-robin pointer=0, timer=0, latched request=0.
  - Reset mid-transaction drops the command immediately, since cmd bit30=0; no ack is issued.
- IDLE:
  - If any req_i bit is set, grant the first requester at or after the pointer, scanning upward with wrap.
  - Latch idx, we, addr and wdata; set busy_o=1; go to ISSUE.
  - Requests arriving in any other state wait.
- ISSUE (1 cycle):
  - spi_cmd_o <= {1'b0, 1'b1, ~we, 14'b0, (we ? wdata : 8'h00), addr}.
  - Clear timer; go to WAIT.
- WAIT:
  - Hold spi_cmd_o.
  - Completion: spi_resp_i[31]==1 and spi_resp_i[6:0]==latched addr.
    - On a read, rdata_o <= spi_resp_i[14:7].
    - On a write, rdata_o keeps its previous value.
    - Go to RELEASE with ok status.
  - Otherwise timer++. When timer==TIMEOUT-1, go to RELEASE with err status.
  - If completion and expiry fall in the same cycle, completion wins.
- RELEASE:
  - On entry, spi_cmd_o <= 0, which deasserts busy to the master.
  - In the entry cycle, ack_o[idx]=1 for exactly one cycle, with err_o[idx]=1 if the status is err.
  - Pointer <= (idx+1) mod N_REQ.
  - Timer is reset on entry.
  - Remain in RELEASE until spi_resp_i[31]==0 or the timer expires.
  - A second expiry here is silent, with no extra ack. Then go to IDLE and set busy_o=0.
- Requester contract:
  - addr, wdata and we stay stable from req rise until ack.
  - req must drop in the cycle after ack.
  - A req still high after RELEASE is treated as a new request.
  - A req that drops mid-transaction does not cancel it; the ack is still pulsed and is ignored by the requester.
- Latency:
  - Grant to ISSUE is 1 cycle.
  - Ack comes 1 cycle after the completion response is sampled.
  - The minimum idle-to-idle time is 4 cycles plus the master's latency.
- Widths:
  - Timer is $clog2(TIMEOUT)+1 bits.
  - Pointer is $clog2(N_REQ) bits; wrap is explicit for non-power-of-2 N_REQ.

Decomposition:
- Package spi_arb_pkg contains:
  - Field constants: CMD_READY_BIT=31, CMD_BUSY_BIT=30, CMD_RD_BIT=29, CMD_DATA_MSB=14, CMD_DATA_LSB=7, CMD_ADDR_MSB=6.
  - State enum: IDLE, ISSUE, WAIT, RELEASE.
- Sub-module spi_rr_pick: combinational rotating-priority picker.
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant and index.
  - It is reused by future shared-resource arbiters.

Test Plan:
- Single write: req0 with addr=0x15, wdata=0xA5, we=1 → spi_cmd_o=0x40005295; the model returns resp[31]=1 with addr 0x15 after 30 cycles → ack_o=01 once, err_o=0, then spi_cmd_o=0 and busy_o=0 after the model drops ready.
- Single read: req1 with addr=0x7F, we=0 → spi_cmd_o=0x6000007F; resp={1,…,data=0x3C,addr=0x7F} → rdata_o=0x3C in the ack cycle and ack_o=10.
- Contention: req0 and req1 both held continuously from reset → grants alternate 0,1,0,1 over 4 transactions, and no ack overlaps another.
- Timeout: the model never sets ready with TIMEOUT=16 → ack_o and err_o pulse together 16 cycles after ISSUE, and the pointer advances.
- Stale ready: resp[31] stays 1 with a mismatched addr → no completion; the arbiter waits for the matching addr or times out. After ack, the arbiter stays in RELEASE until resp[31]=0.
- Reset mid-WAIT: assert rst → spi_cmd_o=0 immediately (async), no ack is issued, and the next grant starts at requester 0.

Source files
------------

// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_arb_pkg
//  Description : Shared definitions for the SPI EEPROM arbiter: command word
//                field positions, FSM state encoding and a command builder.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_arb_pkg;

  // Command / response word field positions
  localparam int CMD_W         = 32;
  localparam int CMD_READY_BIT = 31;
  localparam int CMD_BUSY_BIT  = 30;
  localparam int CMD_RD_BIT    = 29;
  localparam int CMD_DATA_MSB  = 14;
  localparam int CMD_DATA_LSB  = 7;
  localparam int CMD_ADDR_MSB  = 6;

  localparam int DATA_W = CMD_DATA_MSB - CMD_DATA_LSB + 1;
  localparam int ADDR_W = CMD_ADDR_MSB + 1;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // Assemble a command word: busy set, ready clear, remaining bits zero
  function automatic logic [CMD_W-1:0] build_cmd(
    input logic              rd,
    input logic [DATA_W-1:0] data,
    input logic [ADDR_W-1:0] addr
  );
    logic [CMD_W-1:0] c;
    c                             = '0;
    c[CMD_BUSY_BIT]               = 1'b1;
    c[CMD_RD_BIT]                 = rd;
    c[CMD_DATA_MSB:CMD_DATA_LSB]  = data;
    c[CMD_ADDR_MSB:0]             = addr;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : spi_rr_pick
//  Description : Combinational rotating-priority picker. Grants the first
//                asserted request at or after ptr, scanning upward with wrap.
//                Wrap is explicit so non-power-of-2 N works.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          valid
);

  localparam logic [PW:0] c_n = (PW+1)'(N);

  // Scan offsets 0..N-1 from ptr; the first hit wins
  always_comb begin
    logic [PW:0]   w_sum;
    logic [PW-1:0] w_cand;
    gnt    = '0;
    idx    = '0;
    valid  = 1'b0;
    w_sum  = '0;
    w_cand = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, ptr} + (PW+1)'(i);
      if (w_sum >= c_n) begin
        w_sum = w_sum - c_n;
      end
      w_cand = w_sum[PW-1:0];
      if (!valid && req[w_cand]) begin
        valid       = 1'b1;
        gnt[w_cand] = 1'b1;
        idx         = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_eeprom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_eeprom_arbiter
//  Description : Round-robin arbiter sharing one SPI EEPROM master among
//                N_REQ requesters. Builds the 32-bit command word, waits for
//                the master's matching ready response, returns data with an
//                ack pulse and releases the master. A watchdog aborts a
//                transaction (ack + err) if the master hangs.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_eeprom_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [N_REQ-1:0]      we_i,
  input  logic [7*N_REQ-1:0]    addr_i,
  input  logic [8*N_REQ-1:0]    wdata_i,
  output logic [N_REQ-1:0]      ack_o,
  output logic [N_REQ-1:0]      err_o,
  output logic [7:0]            rdata_o,
  output logic                  busy_o,
  output logic [31:0]           spi_cmd_o,
  input  logic [31:0]           spi_resp_i
);

  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [PW-1:0] c_last_idx = PW'(N_REQ - 1);
  localparam logic [TW-1:0] c_tmax     = TW'(TIMEOUT - 1);

  // Per-requester views of the packed address / data buses
  logic [ADDR_W-1:0] w_addr  [N_REQ];
  logic [DATA_W-1:0] w_wdata [N_REQ];

  generate
    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
      assign w_addr[k]  = addr_i[k*ADDR_W +: ADDR_W];
      assign w_wdata[k] = wdata_i[k*DATA_W +: DATA_W];
    end
  endgenerate

  // State and latched request
  arb_state_e        r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_idx;
  logic [N_REQ-1:0]  r_gnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [TW-1:0]     r_timer;

  // Picker outputs
  logic [N_REQ-1:0]  w_pick_gnt;
  logic [PW-1:0]     w_pick_idx;
  logic              w_pick_valid;

  spi_rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req   (req_i),
    .ptr   (r_ptr),
    .gnt   (w_pick_gnt),
    .idx   (w_pick_idx),
    .valid (w_pick_valid)
  );

  // Completion needs ready plus an echo of our address, so a stale ready
  // left over from another transaction is never mistaken for ours.
  logic          w_done;
  logic          w_expired;
  logic          w_ready;
  logic [PW-1:0] w_ptr_next;

  assign w_ready    = spi_resp_i[CMD_READY_BIT];
  assign w_done     = w_ready && (spi_resp_i[CMD_ADDR_MSB:0] == r_addr);
  assign w_expired  = (r_timer == c_tmax);
  assign w_ptr_next = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;

  // Response bits the arbiter does not interpret
  logic w_unused_resp;
  assign w_unused_resp = ^spi_resp_i[CMD_BUSY_BIT:CMD_DATA_MSB+1];

  // Arbiter FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_gnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_timer   <= '0;
      spi_cmd_o <= '0;
      ack_o     <= '0;
      err_o     <= '0;
      rdata_o   <= '0;
      busy_o    <= 1'b0;
    end else begin
      ack_o <= '0;
      err_o <= '0;
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_idx   <= w_pick_idx;
            r_gnt   <= w_pick_gnt;
            r_we    <= we_i[w_pick_idx];
            r_addr  <= w_addr[w_pick_idx];
            r_wdata <= w_wdata[w_pick_idx];
            busy_o  <= 1'b1;
            r_state <= ISSUE;
          end
        end

        ISSUE: begin
          spi_cmd_o <= build_cmd(~r_we, r_we ? r_wdata : '0, r_addr);
          r_timer   <= '0;
          r_state   <= WAIT;
        end

        WAIT: begin
          // Completion takes priority over a same-cycle expiry
          if (w_done || w_expired) begin
            if (w_done && !r_we) begin
              rdata_o <= spi_resp_i[CMD_DATA_MSB:CMD_DATA_LSB];
            end
            ack_o     <= r_gnt;
            err_o     <= w_done ? '0 : r_gnt;
            spi_cmd_o <= '0;
            r_ptr     <= w_ptr_next;
            r_timer   <= '0;
            r_state   <= RELEASE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        RELEASE: begin
          // Wait for the master to drop ready; a second expiry is silent
          if (!w_ready || w_expired) begin
            busy_o  <= 1'b0;
            r_timer <= '0;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_eeprom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_eeprom_arbiter
//  Description : Self-checking bench for spi_eeprom_arbiter (N_REQ=2,
//                TIMEOUT=16) with a behavioural SPI master model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_eeprom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [13:0] addr;
  logic [15:0] wdata;
  logic [1:0]  ack;
  logic [1:0]  err;
  logic [7:0]  rdata;
  logic        busy;
  logic [31:0] spi_cmd;
  logic [31:0] spi_resp;

  int n_cmp = 0;
  int n_bad = 0;

  // Master model controls: 0 respond after lat, 1 never ready,
  // 2 stale ready (addr 0) then respond after lat, 3 stale ready forever
  int          m_mode;
  int          m_lat;
  logic [7:0]  m_data;
  int          m_cnt;

  always #5 clk = ~clk;

  spi_eeprom_arbiter #(
    .N_REQ   (2),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .we_i       (we),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .ack_o      (ack),
    .err_o      (err),
    .rdata_o    (rdata),
    .busy_o     (busy),
    .spi_cmd_o  (spi_cmd),
    .spi_resp_i (spi_resp)
  );

  // Behavioural SPI master
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_resp <= '0;
      m_cnt    <= 0;
    end else if (!spi_cmd[30]) begin
      m_cnt    <= 0;
      spi_resp <= (m_mode >= 2) ? 32'h8000_0000 : 32'h0;
    end else begin
      m_cnt <= m_cnt + 1;
      if ((m_mode == 0 || m_mode == 2) && m_cnt == m_lat - 1)
        spi_resp <= {1'b1, 16'h0, m_data, spi_cmd[6:0]};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [13:0] addr;
    logic [15:0] wdata;
    int          mode;
    int          lat;
    logic [7:0]  data;
    logic [31:0] e_cmd;
    logic [1:0]  e_ack;
    logic [1:0]  e_err;
    logic [7:0]  e_rdata;
    int          e_lat;
    int          e_rel;
  } vec_t;

  // One complete transaction: request, observe command, ack, release
  task automatic run_vec(input string tag, input vec_t v);
    int n;
    @(negedge clk);
    req = v.req; we = v.we; addr = v.addr; wdata = v.wdata;
    m_mode = v.mode; m_lat = v.lat; m_data = v.data;
    n = 0;
    do begin @(negedge clk); n++; end while (!spi_cmd[30] && n < 20);
    chk({tag, " grant-to-cmd cycles"}, n, 2);
    chk({tag, " cmd"}, spi_cmd, v.e_cmd);
    chk({tag, " busy"}, busy, 1);
    n = 0;
    while (ack == 2'b00 && n < 40) begin @(negedge clk); n++; end
    chk({tag, " cmd-to-ack cycles"}, n, v.e_lat);
    chk({tag, " ack"}, ack, v.e_ack);
    chk({tag, " err"}, err, v.e_err);
    chk({tag, " rdata"}, rdata, v.e_rdata);
    req = 2'b00;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) chk({tag, " ack pulse width"}, {ack, err}, 4'h0);
    end while (busy && n < 40);
    chk({tag, " ack-to-idle cycles"}, n, v.e_rel);
    chk({tag, " cmd cleared"}, spi_cmd, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs [8];

  initial begin
    int n;
    int nack;
    logic [1:0] exp_ack;
    vec_t v;

    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    m_mode = 0; m_lat = 2; m_data = '0;

    //                req    we     addr            wdata         md lat data  cmd           ack    err    rdata  lat rel
    vecs[0] = '{2'b01, 2'b01, {7'h00, 7'h15}, {8'h00, 8'hA5}, 0, 10, 8'h00, 32'h4000_5295, 2'b01, 2'b00, 8'h00, 11, 2};
    vecs[1] = '{2'b10, 2'b00, {7'h7F, 7'h00}, {8'h00, 8'h00}, 0, 5,  8'h3C, 32'h6000_007F, 2'b10, 2'b00, 8'h3C, 6,  2};
    vecs[2] = '{2'b11, 2'b01, {7'h33, 7'h22}, {8'h00, 8'h5A}, 0, 3,  8'h77, 32'h4000_2D22, 2'b01, 2'b00, 8'h3C, 4,  2};
    vecs[3] = '{2'b11, 2'b01, {7'h33, 7'h22}, {8'h00, 8'h5A}, 0, 15, 8'h81, 32'h6000_0033, 2'b10, 2'b00, 8'h81, 16, 2};
    vecs[4] = '{2'b01, 2'b00, {7'h00, 7'h41}, {8'h00, 8'h00}, 1, 0,  8'h00, 32'h6000_0041, 2'b01, 2'b01, 8'h81, 16, 1};
    vecs[5] = '{2'b11, 2'b10, {7'h0A, 7'h00}, {8'hFF, 8'h00}, 2, 8,  8'h12, 32'h4000_7F8A, 2'b10, 2'b00, 8'h81, 9,  16};
    vecs[6] = '{2'b01, 2'b00, {7'h00, 7'h55}, {8'h00, 8'h00}, 3, 0,  8'h00, 32'h6000_0055, 2'b01, 2'b01, 8'h81, 16, 16};
    vecs[7] = '{2'b01, 2'b00, {7'h00, 7'h01}, {8'h00, 8'h00}, 0, 1,  8'hC3, 32'h6000_0001, 2'b01, 2'b00, 8'hC3, 2,  2};

    repeat (3) @(negedge clk);
    chk("reset cmd",   spi_cmd, 32'h0);
    chk("reset ack",   ack, 2'b00);
    chk("reset err",   err, 2'b00);
    chk("reset rdata", rdata, 8'h00);
    chk("reset busy",  busy, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Contention: both requests held continuously from reset
    do_reset();
    we = 2'b00; addr = {7'h20, 7'h10}; m_mode = 0; m_lat = 2; m_data = 8'h5E;
    req = 2'b11;
    nack = 0; n = 0; exp_ack = 2'b01;
    while (nack < 4 && n < 300) begin
      @(negedge clk); n++;
      if (ack != 2'b00) begin
        chk($sformatf("rr ack #%0d", nack), ack, exp_ack);
        exp_ack = ~exp_ack;
        nack++;
      end
    end
    chk("rr ack count", nack, 4);
    req = 2'b00;
    n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    chk("rr idle reached", busy, 1'b0);

    // Reset mid-WAIT: advance pointer to 1, start req1, reset during WAIT
    v = '{2'b01, 2'b00, {7'h00, 7'h10}, 16'h0, 0, 2, 8'h99, 32'h6000_0010, 2'b01, 2'b00, 8'h99, 3, 2};
    run_vec("pre-reset", v);
    @(negedge clk);
    req = 2'b10; addr = {7'h7F, 7'h00}; m_mode = 1;
    n = 0;
    while (!spi_cmd[30] && n < 20) begin @(negedge clk); n++; end
    chk("midwait cmd busy", spi_cmd[30], 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async reset cmd", spi_cmd, 32'h0);
    chk("async reset busy", busy, 1'b0);
    req = 2'b00;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      if (ack != 2'b00) n++;
    end
    chk("no ack after reset", n, 0);
    chk("rdata after reset", rdata, 8'h00);
    m_mode = 0; m_lat = 2; addr = {7'h22, 7'h11};
    req = 2'b11;
    n = 0;
    while (ack == 2'b00 && n < 40) begin @(negedge clk); n++; end
    chk("post-reset grant", ack, 2'b01);
    req = 2'b00;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
